// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding, default width and counter sizing for the serial adder
package serial_arith_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    localparam int DEFAULT_WIDTH = 8;
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle between a requester and the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (
        output start, sub, cin, op_a, op_b,
        input  ready, busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, sub, cin, op_a, op_b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit sum/carry cell
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ cin_i;
    assign carry_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial add/subtract sequencer around one full-adder cell
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q, carry_prev_q;
    logic             ready_q, busy_q, done_q, cout_q, ovf_q;
    logic             s, c, last;
    full_adder_cell u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (s),
        .carry_o(c)
    );
    assign res_d = {s, res_q[WIDTH-1:1]};
    assign last  = cnt_q == CW'(WIDTH - 1);
    // Subtraction is A + ~B + 1, so the operand is inverted at capture time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            carry_prev_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    a_q     <= bus.op_a;
                    b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
                    carry_q <= bus.sub | bus.cin;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= c;
                    cnt_q   <= last ? '0 : cnt_q + CW'(1);
                    if (last) begin
                        carry_prev_q <= carry_q;
                        sum_q        <= res_d;
                        cout_q       <= c;
                        ovf_q        <= carry_q ^ c;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector table plus hand-written corner sequences
module tb_serial_adder_ctrl;
    localparam int W = 8;
    typedef struct {
        logic         sub;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs [9];
    always #5 clk = ~clk;
    serial_adder_ctrl_if #(.WIDTH(W)) bus ();
    serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic do_op(input string nm, input logic s, input logic ci, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] es, input logic ec, input logic eo);
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.sub = s; bus.cin = ci; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.sub = ~s; bus.cin = ~ci; bus.op_a = ~a; bus.op_b = ~b;
        k = 0;
        while (!bus.done && k < 3 * W) begin
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, k, W);
        check({nm, " sum/cout/ovf"}, {bus.sum, bus.cout, bus.ovf}, {es, ec, eo});
        @(negedge clk);
        check({nm, " ready/busy/done after"}, {bus.ready, bus.busy, bus.done}, 3'b100);
    endtask
    function automatic logic [W-1:0] fa(input int n);
        return W'(n * 13 + 5);
    endfunction
    function automatic logic [W-1:0] fb(input int n);
        return W'(n * 7 + 1);
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        int k, nd, nb;
        logic busy_drop, prev_done, consec;
        logic [W:0] t;
        vecs[0] = '{1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.op_a = '0; bus.op_b = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset outputs", {bus.ready, bus.busy, bus.done, bus.sum, bus.cout, bus.ovf},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        rst = 1'b0;
        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
                  vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        // start pulses during SHIFT and during DONE must be dropped
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0; bus.op_a = 8'h01; bus.op_b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        busy_drop = 1'b0;
        while (!bus.done && k < 3 * W) begin
            if (!bus.busy) busy_drop = 1'b1;
            bus.start = (k == 2);
            bus.op_a = 8'hFF; bus.op_b = 8'hFF;
            @(negedge clk);
            k++;
        end
        check("ignore latency", k, W);
        check("ignore busy held", busy_drop, 1'b0);
        check("ignore result", {bus.sum, bus.cout, bus.ovf}, {8'h02, 1'b0, 1'b0});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignore after done", {bus.ready, bus.busy, bus.done}, 3'b100);
        nd = 0; nb = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) nb++;
        end
        check("ignore no second done", nd, 0);
        check("ignore no second busy", nb, 0);
        check("ignore sum held", bus.sum, 8'h02);
        // asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.op_a = 8'h11; bus.op_b = 8'h22;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async reset outputs", {bus.ready, bus.busy, bus.done, bus.sum, bus.cout, bus.ovf},
                 {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("reset no done", nd, 0);
        do_op("post reset", 1'b0, 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);
        // start held high: an op every W+2 cycles, each using its own accept-edge operands
        bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0; bus.op_a = fa(0); bus.op_b = fb(0);
        nd = 0; prev_done = 1'b0; consec = 1'b0;
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            check($sformatf("b2b done pattern m=%0d", m), bus.done, (m % 10) == 9);
            if (bus.done) begin
                nd++;
                t = {1'b0, fa(m - 9)} + {1'b0, fb(m - 9)};
                check($sformatf("b2b result m=%0d", m), {bus.sum, bus.cout, bus.ovf},
                      {t[W-1:0], t[W], (fa(m - 9) >> (W - 1)) == (fb(m - 9) >> (W - 1)) &&
                                       t[W-1] != fa(m - 9) >> (W - 1)});
            end
            if (prev_done && bus.done) consec = 1'b1;
            prev_done = bus.done;
            bus.op_a = fa(m); bus.op_b = fb(m);
        end
        bus.start = 1'b0;
        check("b2b done count", nd, 4);
        check("b2b no consecutive done", consec, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
